// File: rtl/simple_loopback_role_if.sv
// Shell-facing data types and the bundled role/shell signal set.
// The role connects through the slave modport; the shell side uses master.
package simple_loopback_role_pkg;

   typedef struct packed {
      logic         valid;
      logic         is_write;
      logic [63:0]  addr;
      logic [511:0] data;
   } mem_req_t;

   typedef struct packed {
      logic         valid;
      logic [511:0] data;
   } mem_resp_t;

   typedef struct packed {
      logic         valid;
      logic [127:0] data;
      logic [15:0]  slot;
      logic [3:0]   pad;
      logic         last;
   } pcie_packet_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] addr;
      logic [63:0] data;
   } softreg_req_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } softreg_resp_t;

   typedef struct packed {
      logic         valid;
      logic [127:0] data;
      logic         last;
   } sl3_data_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } sl3_oob_t;

endpackage

interface simple_loopback_role_if;
   import simple_loopback_role_pkg::*;

   mem_req_t      [1:0] mem_reqs;
   logic          [1:0] mem_req_grants;
   mem_resp_t     [1:0] mem_resps;
   logic          [1:0] mem_resp_grants;

   pcie_packet_t        pcie_packet_in;
   logic                pcie_full_out;
   pcie_packet_t        pcie_packet_out;
   logic                pcie_grant_in;

   softreg_req_t        softreg_req;
   softreg_resp_t       softreg_resp;

   sl3_data_t           sl_tx_out;
   sl3_oob_t            sl_tx_oob_out;
   logic                sl_rx_grant_out;
   logic                sl_rx_oob_grant_out;
   logic                sl_tx_full_in;
   logic                sl_tx_oob_full_in;
   sl3_data_t           sl_rx_in;
   sl3_oob_t            sl_rx_oob_in;

   modport master (
      input  mem_reqs, mem_resp_grants, pcie_full_out, pcie_packet_out, softreg_resp,
             sl_tx_out, sl_tx_oob_out, sl_rx_grant_out, sl_rx_oob_grant_out,
      output mem_req_grants, mem_resps, pcie_packet_in, pcie_grant_in, softreg_req,
             sl_tx_full_in, sl_tx_oob_full_in, sl_rx_in, sl_rx_oob_in
   );

   modport slave (
      output mem_reqs, mem_resp_grants, pcie_full_out, pcie_packet_out, softreg_resp,
             sl_tx_out, sl_tx_oob_out, sl_rx_grant_out, sl_rx_oob_grant_out,
      input  mem_req_grants, mem_resps, pcie_packet_in, pcie_grant_in, softreg_req,
             sl_tx_full_in, sl_tx_oob_full_in, sl_rx_in, sl_rx_oob_in
   );

endinterface

// File: rtl/simple_loopback_role.sv
// Loopback role: echoes PCIe packets through a FIFO and runs single DRAM
// reads/writes on either channel under soft-register control.
module simple_loopback_role
   import simple_loopback_role_pkg::*;
#(
   parameter int PCIE_LOG_DEPTH = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   simple_loopback_role_if.slave io_shell
);

   localparam int                      DEPTH      = 1 << PCIE_LOG_DEPTH;
   localparam logic [PCIE_LOG_DEPTH:0]   FULL_COUNT = (PCIE_LOG_DEPTH + 1)'(DEPTH);
   localparam logic [PCIE_LOG_DEPTH:0]   CNT_ONE    = (PCIE_LOG_DEPTH + 1)'(1);
   localparam logic [PCIE_LOG_DEPTH-1:0] PTR_ONE    = PCIE_LOG_DEPTH'(1);

   localparam logic [31:0] ADDR_SCRATCH  = 32'd0;
   localparam logic [31:0] ADDR_DRAM_ADR = 32'd1;
   localparam logic [31:0] ADDR_PATTERN  = 32'd2;
   localparam logic [31:0] ADDR_CMD      = 32'd3;
   localparam logic [31:0] ADDR_RD_DATA  = 32'd4;
   localparam logic [31:0] ADDR_STATUS   = 32'd5;
   localparam logic [31:0] ADDR_LOOP_CNT = 32'd6;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  slot;
      logic [3:0]   pad;
      logic         last;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } dram_state_e;

   // ---------------------------------------------------------------------
   // PCIe loopback FIFO
   // ---------------------------------------------------------------------
   fifo_entry_t               r_fifo_mem [DEPTH];
   logic [PCIE_LOG_DEPTH-1:0] r_wr_ptr;
   logic [PCIE_LOG_DEPTH-1:0] r_rd_ptr;
   logic [PCIE_LOG_DEPTH:0]   r_count;
   logic [63:0]               r_loop_cnt;

   logic         w_full;
   logic         w_empty;
   logic         w_push;
   logic         w_pop;
   fifo_entry_t  w_head;
   pcie_packet_t w_pkt_out;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);
   assign w_push  = io_shell.pcie_packet_in.valid && !w_full;
   assign w_pop   = !w_empty && io_shell.pcie_grant_in;

   // NOTE: the storage array is not reset; the count and pointers alone say which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= '{data: io_shell.pcie_packet_in.data,
                                   slot: io_shell.pcie_packet_in.slot,
                                   pad:  io_shell.pcie_packet_in.pad,
                                   last: io_shell.pcie_packet_in.last};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_loop_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            r_loop_cnt <= r_loop_cnt + 64'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head = r_fifo_mem[r_rd_ptr];

   always_comb begin
      w_pkt_out = '0;
      if (!w_empty) begin
         w_pkt_out.valid = 1'b1;
         w_pkt_out.data  = w_head.data;
         w_pkt_out.slot  = w_head.slot;
         w_pkt_out.pad   = w_head.pad;
         w_pkt_out.last  = w_head.last;
      end
   end

   assign io_shell.pcie_packet_out = w_pkt_out;
   assign io_shell.pcie_full_out   = w_full;

   // ---------------------------------------------------------------------
   // Soft-register file
   // ---------------------------------------------------------------------
   logic [63:0] r_scratch;
   logic [63:0] r_dram_addr;
   logic [63:0] r_pattern;
   logic [63:0] r_cmd;
   logic [63:0] r_rd_data;
   logic [31:0] r_done_cnt;
   logic        r_resp_valid;
   logic [63:0] r_resp_data;

   logic        w_sr_wr;
   logic        w_sr_rd;
   logic        w_cmd_wr;
   logic        w_busy;
   logic [63:0] w_rd_mux;

   assign w_sr_wr  = io_shell.softreg_req.valid && io_shell.softreg_req.is_write;
   assign w_sr_rd  = io_shell.softreg_req.valid && !io_shell.softreg_req.is_write;
   assign w_cmd_wr = w_sr_wr && (io_shell.softreg_req.addr == ADDR_CMD);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_rd_mux = '0;
      case (io_shell.softreg_req.addr)
         ADDR_SCRATCH:  w_rd_mux = r_scratch;
         ADDR_DRAM_ADR: w_rd_mux = r_dram_addr;
         ADDR_PATTERN:  w_rd_mux = r_pattern;
         ADDR_CMD:      w_rd_mux = r_cmd;
         ADDR_RD_DATA:  w_rd_mux = r_rd_data;
         ADDR_STATUS:   w_rd_mux = {r_done_cnt, 31'd0, w_busy};
         ADDR_LOOP_CNT: w_rd_mux = r_loop_cnt;
         default:       w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scratch    <= '0;
         r_dram_addr  <= '0;
         r_pattern    <= '0;
         r_cmd        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         r_resp_valid <= w_sr_rd;
         r_resp_data  <= w_sr_rd ? w_rd_mux : 64'd0;
         if (w_sr_wr) begin
            case (io_shell.softreg_req.addr)
               ADDR_SCRATCH:  r_scratch   <= io_shell.softreg_req.data;
               ADDR_DRAM_ADR: r_dram_addr <= io_shell.softreg_req.data;
               ADDR_PATTERN:  r_pattern   <= io_shell.softreg_req.data;
               ADDR_CMD:      r_cmd       <= io_shell.softreg_req.data;
               default:       ;
            endcase
         end
      end
   end

   assign io_shell.softreg_resp = '{valid: r_resp_valid, data: r_resp_data};

   // ---------------------------------------------------------------------
   // DRAM single-operation FSM
   // ---------------------------------------------------------------------
   dram_state_e r_state;
   dram_state_e w_next_state;
   logic        r_chan;
   logic        r_is_write;
   logic [63:0] r_req_addr;
   logic [63:0] r_req_pattern;

   mem_req_t [1:0] w_mem_reqs;
   logic     [1:0] w_resp_grants;
   logic           w_op_done;
   logic           w_capture;

   assign w_busy = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_mem_reqs    = '0;
      w_resp_grants = '0;
      w_op_done     = 1'b0;
      w_capture     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_wr) w_next_state = ST_REQ;
         end
         ST_REQ: begin
            w_mem_reqs[r_chan].valid    = 1'b1;
            w_mem_reqs[r_chan].is_write = r_is_write;
            w_mem_reqs[r_chan].addr     = r_req_addr;
            w_mem_reqs[r_chan].data     = r_is_write ? {8{r_req_pattern}} : 512'd0;
            if (io_shell.mem_req_grants[r_chan]) begin
               w_next_state = r_is_write ? ST_IDLE : ST_RESP;
               w_op_done    = r_is_write;
            end
         end
         ST_RESP: begin
            w_resp_grants[r_chan] = io_shell.mem_resps[r_chan].valid;
            if (io_shell.mem_resps[r_chan].valid) begin
               w_next_state = ST_IDLE;
               w_op_done    = 1'b1;
               w_capture    = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operands are snapshotted at command time so a later register write cannot disturb a pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chan        <= 1'b0;
         r_is_write    <= 1'b0;
         r_req_addr    <= '0;
         r_req_pattern <= '0;
         r_rd_data     <= '0;
         r_done_cnt    <= '0;
      end else begin
         if (r_state == ST_IDLE && w_cmd_wr) begin
            r_chan        <= io_shell.softreg_req.data[0];
            r_is_write    <= io_shell.softreg_req.data[1];
            r_req_addr    <= r_dram_addr;
            r_req_pattern <= r_pattern;
         end
         if (w_capture) r_rd_data <= io_shell.mem_resps[r_chan].data[63:0];
         if (w_op_done) r_done_cnt <= r_done_cnt + 32'd1;
      end
   end

   assign io_shell.mem_reqs        = w_mem_reqs;
   assign io_shell.mem_resp_grants = w_resp_grants;

   // ---------------------------------------------------------------------
   // SL3 is not used by this role
   // ---------------------------------------------------------------------
   assign io_shell.sl_tx_out           = '0;
   assign io_shell.sl_tx_oob_out       = '0;
   assign io_shell.sl_rx_grant_out     = 1'b0;
   assign io_shell.sl_rx_oob_grant_out = 1'b0;

   logic w_unused;
   assign w_unused = ^{io_shell.sl_tx_full_in, io_shell.sl_tx_oob_full_in,
                       io_shell.sl_rx_in, io_shell.sl_rx_oob_in,
                       io_shell.mem_resps[0].data[511:64], io_shell.mem_resps[1].data[511:64]};

endmodule

// File: tb/tb_simple_loopback_role.sv
// Scenario bench for simple_loopback_role: PCIe echo scoreboard, soft registers
// and the DRAM command FSM against a small bench-side memory model.
module tb_simple_loopback_role;
   import simple_loopback_role_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   pcie_packet_t exp_q[$];
   logic [511:0] dram_model [logic [63:0]];

   simple_loopback_role_if bus ();

   simple_loopback_role #(.PCIE_LOG_DEPTH(9)) dut (
      .clk      (clk),
      .rst      (rst),
      .io_shell (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
      bus.softreg_req = '{valid: 1'b1, is_write: 1'b1, addr: a, data: d};
      @(negedge clk);
      bus.softreg_req = '0;
   endtask

   task automatic sr_read(input logic [31:0] a, output logic v1, output logic [63:0] d, output logic v2);
      bus.softreg_req = '{valid: 1'b1, is_write: 1'b0, addr: a, data: 64'd0};
      @(negedge clk);
      v1 = bus.softreg_resp.valid;
      d  = bus.softreg_resp.data;
      bus.softreg_req = '0;
      @(negedge clk);
      v2 = bus.softreg_resp.valid;
   endtask

   function automatic pcie_packet_t make_pkt(input logic [127:0] d, input logic [15:0] s,
                                             input logic [3:0] p, input logic l);
      pcie_packet_t pk;
      pk.valid = 1'b1;
      pk.data  = d;
      pk.slot  = s;
      pk.pad   = p;
      pk.last  = l;
      return pk;
   endfunction

   task automatic test_reset();
      logic v1, v2;
      logic [63:0] d;
      rst = 1'b1;
      bus.mem_req_grants = '0;
      bus.mem_resps      = '0;
      bus.pcie_packet_in = '0;
      bus.pcie_grant_in  = 1'b0;
      bus.softreg_req    = '0;
      bus.sl_tx_full_in = 1'b0; bus.sl_tx_oob_full_in = 1'b0;
      bus.sl_rx_in = '0; bus.sl_rx_oob_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.mem_reqs !== '0 || bus.mem_resp_grants !== 2'b00 || bus.pcie_full_out !== 1'b0 ||
          bus.pcie_packet_out !== '0 || bus.softreg_resp !== '0 || bus.sl_tx_out !== '0 ||
          bus.sl_tx_oob_out !== '0 || bus.sl_rx_grant_out !== 1'b0 || bus.sl_rx_oob_grant_out !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: pkt_valid=%b full=%b resp=%b grants=%b req_valid=%b%b, wanted all 0",
                  bus.pcie_packet_out.valid, bus.pcie_full_out, bus.softreg_resp.valid,
                  bus.mem_resp_grants, bus.mem_reqs[1].valid, bus.mem_reqs[0].valid);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus.mem_reqs !== '0 || bus.mem_resp_grants !== 2'b00 || bus.pcie_packet_out.valid !== 1'b0 ||
          bus.softreg_resp.valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_outputs: pkt_valid=%b resp=%b grants=%b, wanted 0",
                  bus.pcie_packet_out.valid, bus.softreg_resp.valid, bus.mem_resp_grants);
      end
      sr_read(32'd5, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd0 || v2 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_status: valid=%b data=%h next_valid=%b, wanted 1 0 0", v1, d, v2);
      end
   endtask

   task automatic test_scratch();
      logic v1, v2;
      logic [63:0] d;
      sr_write(32'd0, 64'hDEADBEEF);
      sr_read(32'd0, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'hDEADBEEF || v2 !== 1'b0) begin
         n_bad++;
         $display("FAIL scratch_read: valid=%b data=%h next_valid=%b, wanted 1 deadbeef 0", v1, d, v2);
      end
      sr_read(32'd9, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd0) begin
         n_bad++;
         $display("FAIL undefined_read: valid=%b data=%h, wanted 1 0", v1, d);
      end
      sr_write(32'd4, 64'h1234);
      sr_read(32'd4, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd0) begin
         n_bad++;
         $display("FAIL rd_data_readonly: valid=%b data=%h, wanted 1 0", v1, d);
      end
   endtask

   task automatic test_pcie_echo();
      pcie_packet_t pk;
      int popped;
      logic v1, v2;
      logic [63:0] d;
      popped = 0;
      bus.pcie_grant_in = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (bus.pcie_packet_out.valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL echo_extra: got %h, wanted no packet", bus.pcie_packet_out);
            end else begin
               pk = exp_q.pop_front();
               popped++;
               if (bus.pcie_packet_out !== pk) begin
                  n_bad++;
                  $display("FAIL echo_packet: got %h, wanted %h", bus.pcie_packet_out, pk);
               end
            end
         end
         if (cyc < 3) begin
            pk = make_pkt(128'(cyc + 1), 16'd2, 4'(cyc + 5), cyc == 2);
            bus.pcie_packet_in = pk;
            exp_q.push_back(pk);
         end else begin
            bus.pcie_packet_in = '0;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (popped != 3 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL echo_count: got %0d packets (%0d left), wanted 3 (0 left)", popped, exp_q.size());
      end
      sr_read(32'd6, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd3) begin
         n_bad++;
         $display("FAIL loop_cnt_echo: valid=%b data=%0d, wanted 1 3", v1, d);
      end
   endtask

   task automatic test_pcie_backpressure();
      pcie_packet_t pk;
      int popped;
      bit full_checked;
      logic v1, v2;
      logic [63:0] d;
      popped = 0;
      full_checked = 1'b0;
      bus.pcie_grant_in = 1'b0;
      for (int i = 0; i < 512; i++) begin
         if (i == 511) begin
            n_cmp++;
            if (bus.pcie_full_out !== 1'b0) begin
               n_bad++;
               $display("FAIL full_at_511: got %b, wanted 0", bus.pcie_full_out);
            end
         end
         pk = make_pkt({32'hA5A5_0000 + 32'(i), 96'(i * 7)}, 16'(i), 4'(i), i[0]);
         bus.pcie_packet_in = pk;
         exp_q.push_back(pk);
         @(negedge clk);
      end
      bus.pcie_packet_in = '0;
      n_cmp++;
      if (bus.pcie_full_out !== 1'b1) begin
         n_bad++;
         $display("FAIL full_at_512: got %b, wanted 1", bus.pcie_full_out);
      end
      bus.pcie_packet_in = make_pkt(128'hBAD0_BAD0, 16'hFFFF, 4'hF, 1'b1);
      @(negedge clk);
      bus.pcie_packet_in = '0;
      n_cmp++;
      if (bus.pcie_full_out !== 1'b1) begin
         n_bad++;
         $display("FAIL full_after_drop: got %b, wanted 1", bus.pcie_full_out);
      end
      bus.pcie_grant_in = 1'b1;
      for (int cyc = 0; cyc < 540; cyc++) begin
         if (bus.pcie_packet_out.valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL drain_extra: got %h, wanted no packet", bus.pcie_packet_out);
            end else begin
               pk = exp_q.pop_front();
               popped++;
               if (bus.pcie_packet_out !== pk) begin
                  n_bad++;
                  $display("FAIL drain_packet: got %h, wanted %h", bus.pcie_packet_out, pk);
               end
            end
         end
         @(negedge clk);
         if (popped == 1 && !full_checked) begin
            full_checked = 1'b1;
            n_cmp++;
            if (bus.pcie_full_out !== 1'b0) begin
               n_bad++;
               $display("FAIL full_after_pop: got %b, wanted 0", bus.pcie_full_out);
            end
         end
      end
      n_cmp++;
      if (popped != 512 || exp_q.size() != 0 || bus.pcie_packet_out.valid !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_count: got %0d (%0d left, valid=%b), wanted 512 (0 left, valid=0)",
                  popped, exp_q.size(), bus.pcie_packet_out.valid);
      end
      sr_read(32'd6, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd515) begin
         n_bad++;
         $display("FAIL loop_cnt_drain: valid=%b data=%0d, wanted 1 515", v1, d);
      end
   endtask

   task automatic test_dram_write_read();
      localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;
      mem_req_t exp_req;
      logic v1, v2;
      logic [63:0] d;
      sr_write(32'd1, 64'h40);
      sr_write(32'd2, PAT);
      sr_write(32'd3, 64'h3);
      exp_req = '{valid: 1'b1, is_write: 1'b1, addr: 64'h40, data: {8{PAT}}};
      n_cmp++;
      if (bus.mem_reqs[1] !== exp_req || bus.mem_reqs[0] !== '0) begin
         n_bad++;
         $display("FAIL dram_write_req: got %h / ch0 valid %b, wanted %h", bus.mem_reqs[1],
                  bus.mem_reqs[0].valid, exp_req);
      end
      dram_model[64'h40] = {8{PAT}};
      bus.mem_req_grants = 2'b10;
      @(negedge clk);
      bus.mem_req_grants = 2'b00;
      n_cmp++;
      if (bus.mem_reqs !== '0) begin
         n_bad++;
         $display("FAIL dram_write_done: req valid %b%b, wanted 00", bus.mem_reqs[1].valid, bus.mem_reqs[0].valid);
      end
      sr_write(32'd3, 64'h1);
      exp_req = '{valid: 1'b1, is_write: 1'b0, addr: 64'h40, data: 512'd0};
      n_cmp++;
      if (bus.mem_reqs[1] !== exp_req || bus.mem_reqs[0] !== '0) begin
         n_bad++;
         $display("FAIL dram_read_req: got %h, wanted %h", bus.mem_reqs[1], exp_req);
      end
      bus.mem_req_grants = 2'b10;
      @(negedge clk);
      bus.mem_req_grants = 2'b00;
      n_cmp++;
      if (bus.mem_resp_grants !== 2'b00 || bus.mem_reqs !== '0) begin
         n_bad++;
         $display("FAIL dram_resp_wait: resp_grants=%b, wanted 00", bus.mem_resp_grants);
      end
      bus.mem_resps[1] = '{valid: 1'b1, data: dram_model[64'h40]};
      bus.mem_resps[0] = '{valid: 1'b1, data: 512'hFEED};
      #1;
      n_cmp++;
      if (bus.mem_resp_grants !== 2'b10) begin
         n_bad++;
         $display("FAIL dram_resp_grant: got %b, wanted 10", bus.mem_resp_grants);
      end
      @(negedge clk);
      bus.mem_resps = '0;
      sr_read(32'd4, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== PAT) begin
         n_bad++;
         $display("FAIL dram_rd_data: valid=%b data=%h, wanted 1 %h", v1, d, PAT);
      end
      sr_read(32'd5, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== {32'd2, 32'd0}) begin
         n_bad++;
         $display("FAIL dram_status_2: valid=%b data=%h, wanted 1 %h", v1, d, {32'd2, 32'd0});
      end
   endtask

   task automatic test_grant_delay();
      localparam logic [63:0] PAT2 = 64'h1111_2222_3333_4444;
      mem_req_t exp_req;
      logic v1, v2;
      logic [63:0] d;
      sr_write(32'd1, 64'h80);
      sr_write(32'd2, PAT2);
      sr_write(32'd3, 64'h2);
      exp_req = '{valid: 1'b1, is_write: 1'b1, addr: 64'h80, data: {8{PAT2}}};
      for (int step = 0; step < 4; step++) begin
         n_cmp++;
         if (bus.mem_reqs[0] !== exp_req || bus.mem_reqs[1] !== '0) begin
            n_bad++;
            $display("FAIL delay_req_stable[%0d]: got %h, wanted %h", step, bus.mem_reqs[0], exp_req);
         end
         case (step)
            0: sr_write(32'd2, 64'hFFFF_0000_FFFF_0000);
            1: sr_write(32'd3, 64'h3);
            2: begin
               sr_read(32'd5, v1, d, v2);
               n_cmp++;
               if (v1 !== 1'b1 || d !== {32'd2, 32'd1}) begin
                  n_bad++;
                  $display("FAIL delay_busy: valid=%b data=%h, wanted 1 %h", v1, d, {32'd2, 32'd1});
               end
            end
            default: @(negedge clk);
         endcase
      end
      bus.mem_req_grants = 2'b01;
      @(negedge clk);
      bus.mem_req_grants = 2'b00;
      sr_read(32'd5, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== {32'd3, 32'd0}) begin
         n_bad++;
         $display("FAIL delay_status_3: valid=%b data=%h, wanted 1 %h", v1, d, {32'd3, 32'd0});
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.mem_reqs !== '0) begin
         n_bad++;
         $display("FAIL ignored_cmd: req valid %b%b, wanted 00", bus.mem_reqs[1].valid, bus.mem_reqs[0].valid);
      end
      sr_read(32'd3, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'h3) begin
         n_bad++;
         $display("FAIL cmd_readback: valid=%b data=%h, wanted 1 3", v1, d);
      end
   endtask

   task automatic test_reset_mid_op();
      logic v1, v2;
      logic [63:0] d;
      sr_write(32'd1, 64'h100);
      sr_write(32'd3, 64'h0);
      bus.mem_req_grants = 2'b01;
      @(negedge clk);
      bus.mem_req_grants = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.mem_resps[0] = '{valid: 1'b1, data: 512'h5555};
      #1;
      n_cmp++;
      if (bus.mem_resp_grants !== 2'b00) begin
         n_bad++;
         $display("FAIL late_resp_grant: got %b, wanted 00", bus.mem_resp_grants);
      end
      sr_read(32'd5, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd0 || bus.mem_resp_grants !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_mid_status: valid=%b data=%h grants=%b, wanted 1 0 00", v1, d, bus.mem_resp_grants);
      end
      sr_read(32'd4, v1, d, v2);
      n_cmp++;
      if (v1 !== 1'b1 || d !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_mid_rd_data: valid=%b data=%h, wanted 1 0", v1, d);
      end
      bus.mem_resps = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      @(negedge clk);
      test_reset();
      test_scratch();
      test_pcie_echo();
      test_pcie_backpressure();
      test_dram_write_read();
      test_grant_delay();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
